// File: rtl/ov5640_init_sequencer.sv
// rtl/ov5640_init_sequencer.sv - walks the OV5640 init register table and feeds each entry to the SCCB write master
module ov5640_init_sequencer #(
    parameter int DATA_WIDTH     = 24,
    parameter int ADDR_WIDTH     = 8,
    parameter int INIT_NUM       = 86,
    parameter int POWERUP_CYCLES = 1000000,
    parameter int SRST_CYCLES    = 250000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_q_i,
    output logic                  wr_req_o,
    output logic [15:0]           wr_reg_addr_o,
    output logic [7:0]            wr_data_o,
    input  logic                  wr_ack_i,
    input  logic                  wr_done_i,
    input  logic                  wr_err_i,
    output logic                  init_busy_o,
    output logic                  init_done_o,
    output logic                  init_error_o,
    output logic [ADDR_WIDTH-1:0] fail_index_o
);

    localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [23:0] PWR_LOAD  = (POWERUP_CYCLES > 0) ? 24'(POWERUP_CYCLES - 1) : 24'd0;
    localparam logic [23:0] SRST_LOAD = (SRST_CYCLES > 0) ? 24'(SRST_CYCLES - 1) : 24'd0;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INIT_NUM - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_LOAD,
        S_LATCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_SRST_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [23:0]           cnt_q, cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [15:0]           addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic [ADDR_WIDTH-1:0] fail_q, fail_d;
    logic                  advance;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fail_d  = fail_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_PWR_WAIT;
                    idx_d   = '0;
                    retry_d = '0;
                    fail_d  = '0;
                    cnt_d   = PWR_LOAD;
                end
            end
            S_PWR_WAIT: begin
                if (cnt_q == 24'd0) state_d = S_LOAD;
                else                cnt_d   = cnt_q - 24'd1;
            end
            S_LOAD:  state_d = S_LATCH;
            S_LATCH: begin
                addr_d  = rom_q_i[23:8];
                data_d  = rom_q_i[7:0];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (wr_ack_i) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A NACK wins over a simultaneous completion; retries reuse the latched word.
                if (wr_err_i) begin
                    if (int'(retry_q) + 1 < MAX_RETRY) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        fail_d  = idx_q;
                        state_d = S_ERROR;
                    end
                end else if (wr_done_i) begin
                    retry_d = '0;
                    if (addr_q == 16'h3008 && data_q[7]) begin
                        cnt_d   = SRST_LOAD;
                        state_d = S_SRST_WAIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_SRST_WAIT: begin
                if (cnt_q == 24'd0) advance = 1'b1;
                else                cnt_d   = cnt_q - 24'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_LOAD;
            end
        end
    end

    assign rom_addr_o    = idx_q;
    assign wr_req_o      = (state_q == S_ISSUE);
    assign wr_reg_addr_o = addr_q;
    assign wr_data_o     = data_q;
    assign init_busy_o   = (state_q == S_PWR_WAIT) || (state_q == S_LOAD) || (state_q == S_LATCH) ||
                           (state_q == S_ISSUE) || (state_q == S_WAIT_DONE) || (state_q == S_SRST_WAIT);
    assign init_done_o   = (state_q == S_DONE);
    assign init_error_o  = (state_q == S_ERROR);
    assign fail_index_o  = fail_q;

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// tb/tb_ov5640_init_sequencer.sv - transaction-level model bench for ov5640_init_sequencer
module tb_ov5640_init_sequencer;

    localparam int INIT_NUM = 4;
    localparam int PWR      = 10;
    localparam int SRST     = 5;
    localparam int MAXR     = 2;
    localparam int AW       = 8;

    logic          clk = 1'b0;
    logic          reset_i, start_i, wr_ack_i, wr_done_i, wr_err_i;
    logic [23:0]   rom_q;
    logic [AW-1:0] rom_addr_o, fail_index_o;
    logic          wr_req_o, init_busy_o, init_done_o, init_error_o;
    logic [15:0]   wr_reg_addr_o;
    logic [7:0]    wr_data_o;

    always #5 clk = ~clk;

    ov5640_init_sequencer #(
        .DATA_WIDTH(24), .ADDR_WIDTH(AW), .INIT_NUM(INIT_NUM),
        .POWERUP_CYCLES(PWR), .SRST_CYCLES(SRST), .MAX_RETRY(MAXR)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .rom_addr_o(rom_addr_o), .rom_q_i(rom_q),
        .wr_req_o(wr_req_o), .wr_reg_addr_o(wr_reg_addr_o), .wr_data_o(wr_data_o),
        .wr_ack_i(wr_ack_i), .wr_done_i(wr_done_i), .wr_err_i(wr_err_i),
        .init_busy_o(init_busy_o), .init_done_o(init_done_o), .init_error_o(init_error_o),
        .fail_index_o(fail_index_o)
    );

    logic [15:0] tbl_addr [0:3];
    logic [7:0]  tbl_data [0:3];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rom_q <= {tbl_addr[rom_addr_o[1:0]], tbl_data[rom_addr_o[1:0]]};
    end

    // Expected outputs, updated by the driver at the edge where each should take effect
    bit exp_req, exp_busy, exp_done, exp_error, chk_en;
    int exp_idx, exp_rom, exp_fail;
    bit strays, rnd;
    int plan_nerr [0:3];
    int reset_entry;
    int checks = 0, errors = 0;
    int start_cyc;

    logic [23:0] log_q [$];
    int          rise_q [$];
    int          done_q [$];
    logic        req_prev = 1'b0, done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wr_req_o && !req_prev) begin
            log_q.push_back({wr_reg_addr_o, wr_data_o});
            rise_q.push_back(cyc);
        end
        if (init_done_o && !done_prev) done_q.push_back(cyc);
        req_prev  <= wr_req_o;
        done_prev <= init_done_o;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_req", wr_req_o, exp_req);
            chk("init_busy", init_busy_o, exp_busy);
            chk("init_done", init_done_o, exp_done);
            chk("init_error", init_error_o, exp_error);
            chk("rom_addr", rom_addr_o, exp_rom);
            if (exp_req) begin
                chk("wr_reg_addr", wr_reg_addr_o, tbl_addr[exp_idx]);
                chk("wr_data", wr_data_o, tbl_data[exp_idx]);
            end
            if (exp_error) chk("fail_index", fail_index_o, exp_fail);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        wr_ack_i = 1'b0; wr_done_i = 1'b0; wr_err_i = 1'b0; start_i = 1'b0;
    endtask

    // Edges during which the DUT must ignore handshake inputs and start
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            if (strays) begin
                wr_ack_i  = ($urandom_range(0, 3) == 0);
                wr_done_i = ($urandom_range(0, 3) == 0);
                wr_err_i  = ($urandom_range(0, 3) == 0);
                start_i   = (i == 1) || ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        clear_in();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (strays) begin
                wr_ack_i  = ($urandom_range(0, 2) == 0);
                wr_done_i = ($urandom_range(0, 2) == 0);
                wr_err_i  = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        clear_in();
    endtask

    task automatic run_seq();
        int k, att, a, d;
        bit fin, srst;
        log_q.delete(); rise_q.delete(); done_q.delete();
        start_i = 1'b1; tick(); start_i = 1'b0;
        start_cyc = cyc;
        exp_busy = 1; exp_done = 0; exp_error = 0; exp_idx = 0; exp_rom = 0; exp_req = 0;
        gap(PWR + 2);
        exp_req = 1;
        k = 0; att = 0; fin = 0;
        while (!fin) begin
            a = rnd ? $urandom_range(0, 2) : 0;
            repeat (a) tick();
            wr_ack_i = 1'b1; tick(); wr_ack_i = 1'b0;
            exp_req = 0;
            if (k == reset_entry && att == 0) begin
                repeat (rnd ? $urandom_range(0, 2) : 1) tick();
                reset_i = 1'b1; tick(); reset_i = 1'b0;
                exp_busy = 0; exp_done = 0; exp_error = 0; exp_idx = 0; exp_rom = 0;
                chk("reset_wr_reg_addr", wr_reg_addr_o, 0);
                chk("reset_wr_data", wr_data_o, 0);
                tick();
                wr_done_i = 1'b1; tick(); wr_done_i = 1'b0;
                fin = 1;
            end else begin
                d = rnd ? $urandom_range(0, 3) : 1;
                repeat (d) tick();
                if (att < plan_nerr[k]) begin
                    wr_err_i  = 1'b1;
                    wr_done_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    tick();
                    wr_err_i = 1'b0; wr_done_i = 1'b0;
                    att++;
                    if (att >= MAXR) begin
                        exp_busy = 0; exp_error = 1; exp_fail = k; fin = 1;
                    end else begin
                        exp_req = 1;
                    end
                end else begin
                    wr_done_i = 1'b1; tick(); wr_done_i = 1'b0;
                    att = 0;
                    srst = (tbl_addr[k] == 16'h3008) && tbl_data[k][7];
                    if (srst) gap(SRST);
                    if (k == INIT_NUM - 1) begin
                        exp_busy = 0; exp_done = 1; fin = 1;
                    end else begin
                        k++; exp_idx = k; exp_rom = k;
                        gap(2);
                        exp_req = 1;
                    end
                end
            end
        end
        idle(4);
    endtask

    task automatic spec_table();
        tbl_addr[0] = 16'h3008; tbl_data[0] = 8'h82;
        tbl_addr[1] = 16'h3103; tbl_data[1] = 8'h03;
        tbl_addr[2] = 16'h3017; tbl_data[2] = 8'hff;
        tbl_addr[3] = 16'h4300; tbl_data[3] = 8'h03;
    endtask

    task automatic plan_clear();
        for (int i = 0; i < 4; i++) plan_nerr[i] = 0;
        reset_entry = -1;
    endtask

    function automatic int count_word(input logic [23:0] w);
        int n = 0;
        foreach (log_q[i]) if (log_q[i] == w) n++;
        return n;
    endfunction

    function automatic int rise_at(input int i);
        return (rise_q.size() > i) ? rise_q[i] - start_cyc : -1;
    endfunction

    function automatic int done_at();
        return (done_q.size() > 0) ? done_q[0] - start_cyc : -1;
    endfunction

    logic [23:0] happy_words [0:3];

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        happy_words[0] = 24'h300882; happy_words[1] = 24'h310303;
        happy_words[2] = 24'h3017ff; happy_words[3] = 24'h430003;
        reset_i = 1'b1; clear_in();
        spec_table(); plan_clear();
        strays = 0; rnd = 0; exp_fail = 0;
        tick(); tick();
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_wr_req", wr_req_o, 0);
        chk("rst_rom_addr", rom_addr_o, 0);
        chk("rst_wr_reg_addr", wr_reg_addr_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_busy", init_busy_o, 0);
        chk("rst_done", init_done_o, 0);
        chk("rst_error", init_error_o, 0);
        chk("rst_fail_index", fail_index_o, 0);
        chk_en = 1;

        run_seq();
        chk("happy_n_writes", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) chk("happy_write_order", log_q[i], happy_words[i]);
        chk("happy_first_req_latency", rise_at(0), 12);
        chk("happy_srst_gap", rise_at(1), 22);
        chk("happy_done_time", done_at(), 35);
        chk("happy_done_flag", init_done_o, 1);
        chk("happy_busy_flag", init_busy_o, 0);

        tbl_data[0] = 8'h02;
        run_seq();
        chk("nosrst_second_req", rise_at(1), 17);
        spec_table();

        plan_nerr[2] = 1;
        run_seq();
        chk("nack_n_writes", log_q.size(), 5);
        chk("nack_3017_issues", count_word(24'h3017ff), 2);
        chk("nack_error_flag", init_error_o, 0);
        chk("nack_done_flag", init_done_o, 1);

        plan_clear(); plan_nerr[1] = MAXR;
        run_seq();
        chk("fatal_n_writes", log_q.size(), 3);
        chk("fatal_error_flag", init_error_o, 1);
        chk("fatal_fail_index", fail_index_o, 1);
        chk("fatal_wr_req", wr_req_o, 0);
        chk("fatal_later_entries", count_word(24'h3017ff) + count_word(24'h430003), 0);

        plan_clear(); reset_entry = 2;
        run_seq();
        chk("rstmid_n_writes", log_q.size(), 3);
        plan_clear();
        run_seq();
        chk("replay_first_word", (log_q.size() > 0) ? log_q[0] : 24'h0, 24'h300882);
        chk("replay_n_writes", log_q.size(), 4);

        strays = 1;
        run_seq();
        chk("strays_first_req_latency", rise_at(0), 12);
        chk("strays_done_time", done_at(), 35);

        rnd = 1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) begin
                tbl_addr[i] = ($urandom_range(0, 2) == 0) ? 16'h3008 : 16'($urandom);
                tbl_data[i] = 8'($urandom);
                case ($urandom_range(0, 15))
                    0, 1, 2, 3, 4, 5, 6, 7, 8, 9: plan_nerr[i] = 0;
                    10, 11, 12, 13, 14:           plan_nerr[i] = 1;
                    default:                      plan_nerr[i] = MAXR;
                endcase
            end
            reset_entry = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_seq();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
